serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing D = A − B − BI, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the combinational full adder. It serves area-constrained datapaths that accept WIDTH-cycle latency in exchange for one bit cell. Operands load in parallel. The result appears both as a serial bit stream and as a parallel word with final borrow.

## Interface
- WIDTH, 8, operand/result width; legal range 2..32.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE or DONE state.
- A  in  WIDTH  minuend; captured on accepted START.
- B  in  WIDTH  subtrahend; captured on accepted START.
- BI  in  1  borrow-in; captured on accepted START.
- BUSY  out  1  high while in SHIFT.
- DONE  out  1  high while in DONE state; D/BO/OV valid.
- D  out  WIDTH  difference word.
- BO  out  1  final borrow-out (1 = unsigned A < B + BI).
- Y  out  1  difference bit produced by the last shift.
- Y_VALID  out  1  Y carries a new bit this cycle.
- OV  out  1  signed overflow (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, START=1: load A/B shift registers, borrow register ← BI, bit counter ← 0, D ← 0, OV ← 0 → SHIFT.
- IDLE, START=0: stay.
- SHIFT, each cycle: cell inputs a=A_sr[0], b=B_sr[0], br=borrow.
  - Difference bit d = a^b^br; new borrow = (~a&b) | (~(a^b)&br).
  - D ← {d, D[WIDTH-1:1]}; A_sr, B_sr shift right; borrow ← new borrow; Y ← d; counter++.
- SHIFT, counter == WIDTH-1: this shift is the last → DONE. BO ← new borrow.
- DONE: holds D, BO, OV until next accepted START (→ SHIFT, same load as IDLE) or RST.
  - START in DONE gives back-to-back operation; DONE drops the cycle after acceptance.
- START during SHIFT: ignored; operands and result unaffected.
- Arithmetic: modulo 2^WIDTH. No inputs sampled except on an accepted START.

## Timing
- Reset (RST=1 at an edge): state IDLE; BUSY, DONE, D, BO, Y, Y_VALID, OV all 0. RST overrides START.
- RST mid-SHIFT: next cycle is IDLE with all outputs 0; the operation is abandoned.
- START accepted at edge 0: BUSY=1 after edges 0..WIDTH-1.
- After edge k (k=1..WIDTH): Y = D bit k-1, Y_VALID=1.
- After edge WIDTH: DONE=1, BUSY=0, D/BO/OV final.
- Latency START→DONE: WIDTH cycles. Throughput: one result per WIDTH cycles with back-to-back START.
- Y_VALID=0 in every cycle not immediately following a shift edge.

## Configuration
- SERIAL_SUBTRACTOR_OVF_EN defined: OV registered at the final shift as (A[WIDTH-1] != B[WIDTH-1]) && (d != A[WIDTH-1]), where d is the final difference bit and A, B are the captured operand MSBs (held in a dedicated register). BI is excluded from the OV term.
- Not defined: OV tied to 0; MSB capture register and OV logic are absent.

## Structure
- Package serial_subtractor_pkg:
  - State typedef: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - SERIAL_SUBTRACTOR_WIDTH_DEF=8.
  - Counter-width function $clog2(WIDTH).
- Sub-module full_subtractor: combinational bit cell with ports A, B, BI → Y, BO. One instance.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- Reset: RST=1 for 2 cycles with START=1 → all outputs 0, state IDLE, no operation starts.
- A=8'h5A, B=8'h23, BI=0, START pulse → DONE first high 8 cycles later; D=8'h37, BO=0. Y stream LSB-first 1,1,1,0,1,1,0,0.
- A=8'h10, B=8'h20, BI=0 → D=8'hF0, BO=1. A=8'h00, B=8'h00, BI=1 → D=8'hFF, BO=1.
- START=1 held with A/B changing every cycle during SHIFT → first result unchanged. START in DONE → new operation, DONE=0 next cycle, correct second result.
- RST asserted 4 cycles into SHIFT → IDLE and zero outputs next cycle. A later START produces a correct, uncorrupted result.
- A=8'h80, B=8'h01, BI=0 → D=8'h7F, BO=0. OV=1 with SERIAL_SUBTRACTOR_OVF_EN defined, 0 without.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int SERIAL_SUBTRACTOR_WIDTH_DEF = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: Y = A - B - BI, BO = borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic Y,
  output logic BO
);

  assign Y  = A ^ B ^ BI;
  assign BO = (~A & B) | (~(A ^ B) & BI);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - BI, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed-overflow flag OV.
module serial_subtractor #(
  parameter int WIDTH = serial_subtractor_pkg::SERIAL_SUBTRACTOR_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             Y,
  output logic             Y_VALID,
  output logic             OV
);
  import serial_subtractor_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, d_q;
  logic             br_q, bo_q, y_q, yv_q;
  logic             d_bit, br_d;
  logic             load, last_shift;

  // The port DONE shadows the enum literal, so states are referenced by package scope.
  assign load       = START && (state_q != serial_subtractor_pkg::SHIFT);
  assign last_shift = (state_q == serial_subtractor_pkg::SHIFT) && (cnt_q == CW'(WIDTH - 1));

  full_subtractor u_cell (
    .A  (a_sr_q[0]),
    .B  (b_sr_q[0]),
    .BI (br_q),
    .Y  (d_bit),
    .BO (br_d)
  );

  // NOTE: operand shift registers have no reset; every use is preceded by a load.
  always_ff @(posedge CLK) begin
    if (load) begin
      a_sr_q <= A;
      b_sr_q <= B;
    end else if (state_q == serial_subtractor_pkg::SHIFT) begin
      a_sr_q <= a_sr_q >> 1;
      b_sr_q <= b_sr_q >> 1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= serial_subtractor_pkg::IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      yv_q <= 1'b0;
      case (state_q)
        serial_subtractor_pkg::SHIFT: begin
          d_q   <= {d_bit, d_q[WIDTH-1:1]};
          br_q  <= br_d;
          y_q   <= d_bit;
          yv_q  <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (last_shift) begin
            bo_q    <= br_d;
            state_q <= serial_subtractor_pkg::DONE;
          end
        end
        default: begin
          if (START) begin
            d_q     <= '0;
            br_q    <= BI;
            cnt_q   <= '0;
            state_q <= serial_subtractor_pkg::SHIFT;
          end
        end
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic amsb_q, bmsb_q, ov_q;

  always_ff @(posedge CLK) begin
    if (load) begin
      amsb_q <= A[WIDTH-1];
      bmsb_q <= B[WIDTH-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || load) begin
      ov_q <= 1'b0;
    end else if (last_shift) begin
      ov_q <= (amsb_q != bmsb_q) && (d_bit != amsb_q);
    end
  end

  assign OV = ov_q;
`else
  assign OV = 1'b0;
`endif

  assign BUSY    = (state_q == serial_subtractor_pkg::SHIFT);
  assign DONE    = (state_q == serial_subtractor_pkg::DONE);
  assign D       = d_q;
  assign BO      = bo_q;
  assign Y       = y_q;
  assign Y_VALID = yv_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK, RST, START, BI;
  logic [W-1:0] A, B, D;
  logic         BUSY, DONE, BO, Y, Y_VALID, OV;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_d;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BI(BI),
    .BUSY(BUSY), .DONE(DONE), .D(D), .BO(BO), .Y(Y), .Y_VALID(Y_VALID), .OV(OV)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_done"}, 32'(DONE), 0);
    check({tag, "_d"}, 32'(D), 0);
    check({tag, "_bo"}, 32'(BO), 0);
    check({tag, "_y"}, 32'(Y), 0);
    check({tag, "_yv"}, 32'(Y_VALID), 0);
    check({tag, "_ov"}, 32'(OV), 0);
  endtask

  // Called at a negedge; returns at the negedge after the DONE edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit noise);
    logic [W:0]   full;
    logic [W-1:0] exp_d;
    logic         exp_bo, exp_ov;
    full   = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
    exp_d  = full[W-1:0];
    exp_bo = full[W];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    exp_ov = (a[W-1] != b[W-1]) && (exp_d[W-1] != a[W-1]);
`else
    exp_ov = 1'b0;
`endif
    A = a; B = b; BI = bi; START = 1'b1;
    for (int k = 0; k <= W; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (k == 0) check("yv_first", 32'(Y_VALID), 0);
      else begin
        check("yv_shift", 32'(Y_VALID), 1);
        check($sformatf("y_bit%0d", k - 1), 32'(Y), 32'(exp_d[k-1]));
      end
      if (k < W) begin
        check("busy_shift", 32'(BUSY), 1);
        check("done_shift", 32'(DONE), 0);
        if (noise) begin
          START = 1'b1; A = W'($urandom); B = W'($urandom); BI = 1'($urandom);
        end else begin
          START = 1'b0;
        end
      end else begin
        check("busy_end", 32'(BUSY), 0);
        check("done_end", 32'(DONE), 1);
        check("d_final", 32'(D), 32'(exp_d));
        check("bo_final", 32'(BO), 32'(exp_bo));
        check("ov_final", 32'(OV), 32'(exp_ov));
        START = 1'b0;
      end
    end
    last_d = exp_d;
  endtask

  task automatic idle_in_done(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("done_hold", 32'(DONE), 1);
      check("yv_hold", 32'(Y_VALID), 0);
      check("d_hold", 32'(D), 32'(last_d));
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b1; A = 8'h5A; B = 8'h23; BI = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_zero("reset");
    RST = 1'b0; START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("no_start_busy", 32'(BUSY), 0);
    check("no_start_done", 32'(DONE), 0);

    run_op(8'h5A, 8'h23, 1'b0, 1'b0);
    check("d_5a_23", 32'(D), 32'h37);
    idle_in_done(2);
    run_op(8'h10, 8'h20, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    check("d_00_00_bi", 32'(D), 32'hFF);

    // Operand noise with START held, then an immediate back-to-back start from DONE.
    run_op(8'hC3, 8'h4E, 1'b1, 1'b1);
    run_op(8'h21, 8'h9A, 1'b0, 1'b0);

    A = 8'hAA; B = 8'h55; BI = 1'b1; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_zero("mid_reset");
    RST = 1'b0;
    run_op(8'h3C, 8'h0F, 1'b0, 1'b0);

    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    check("d_80_01", 32'(D), 32'h7F);

    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      idle_in_done(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
